// File: rtl/paillier_pkg.sv
// Shared constants and types for the Paillier operand-RAM arbiter.
package paillier_pkg;

    localparam int K           = 2048;
    localparam int ADDR_W      = 11;
    localparam int DATA_W      = 64;
    localparam int NUM_REQ     = 4;
    localparam int RD_LAT      = 1;
    localparam int ID_W        = $clog2(NUM_REQ);
    localparam int BURST_WORDS = K / DATA_W;

    typedef logic [ID_W-1:0] req_id_t;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/paillier_rr_pick.sv
// Rotating-priority picker: one-hot grant to the first valid bit at or after i_ptr.
module paillier_rr_pick #(
    parameter int N    = 4,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    i_valid,
    input  logic [ID_W-1:0] i_ptr,
    output logic [N-1:0]    o_grant,
    output logic [ID_W-1:0] o_id,
    output logic            o_any
);

    logic [ID_W:0]   w_sum;
    logic [ID_W-1:0] w_idx;

    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, otherwise synthesis infers a latch.
    always_comb begin
        o_grant = '0;
        o_id    = '0;
        o_any   = 1'b0;
        w_sum   = '0;
        w_idx   = '0;
        for (int k = 0; k < N; k++) begin
            w_sum = {1'b0, i_ptr} + (ID_W+1)'(k);
            if (w_sum >= (ID_W+1)'(N)) begin
                w_sum = w_sum - (ID_W+1)'(N);
            end
            w_idx = w_sum[ID_W-1:0];
            if (!o_any && i_valid[w_idx]) begin
                o_grant[w_idx] = 1'b1;
                o_id           = w_idx;
                o_any          = 1'b1;
            end
        end
    end

endmodule

// File: rtl/paillier_ram_arbiter.sv
// Round-robin arbiter sharing one single-port operand RAM between Paillier engines,
// with locked bursts and tag-pipelined read-data return.
module paillier_ram_arbiter #(
    parameter int NUM_REQ = paillier_pkg::NUM_REQ,
    parameter int DATA_W  = paillier_pkg::DATA_W,
    parameter int ADDR_W  = paillier_pkg::ADDR_W,
    parameter int RD_LAT  = paillier_pkg::RD_LAT
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ-1:0]         req_wen,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]  req_wdata,
    input  logic [NUM_REQ-1:0]         req_lock,
    output logic [NUM_REQ-1:0]         rsp_valid,
    output logic [DATA_W-1:0]          rsp_data,
    output logic                       ram_wen,
    output logic [ADDR_W-1:0]          ram_addr,
    output logic [DATA_W-1:0]          ram_wr_data,
    input  logic [DATA_W-1:0]          ram_rd_data,
    output logic                       ram_en,
    output logic [$clog2(NUM_REQ)-1:0] owner
);

    import paillier_pkg::*;

    localparam int ID_W = $clog2(NUM_REQ);
    localparam int PIPE = RD_LAT + 1;

    arb_state_e          r_state, w_state_nxt;
    logic [ID_W-1:0]     r_ptr, w_ptr_nxt;
    logic [ID_W-1:0]     r_owner, w_owner_nxt;

    logic [NUM_REQ-1:0]  w_pick_grant;
    logic [ID_W-1:0]     w_pick_id;
    logic                w_pick_any;

    logic [NUM_REQ-1:0]  w_ready;
    logic                w_accept;
    logic [ID_W-1:0]     w_acc_id;
    logic                w_acc_rd;

    logic [PIPE-1:0]     r_tag_v;
    logic [ID_W-1:0]     r_tag_id [PIPE];

    paillier_rr_pick #(
        .N    (NUM_REQ),
        .ID_W (ID_W)
    ) u_pick (
        .i_valid (req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_pick_grant),
        .o_id    (w_pick_id),
        .o_any   (w_pick_any)
    );

    // Grant and next-state: the picker only matters in IDLE; a lock pins the owner.
    always_comb begin
        w_ready     = '0;
        w_accept    = 1'b0;
        w_acc_id    = r_owner;
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_owner_nxt = r_owner;
        case (r_state)
            IDLE: begin
                w_ready  = w_pick_grant;
                w_accept = w_pick_any;
                w_acc_id = w_pick_id;
            end
            LOCKED: begin
                w_ready[r_owner] = req_valid[r_owner];
                w_accept         = req_valid[r_owner];
            end
            default: ;
        endcase
        if (w_accept) begin
            w_owner_nxt = w_acc_id;
            w_ptr_nxt   = (w_acc_id == ID_W'(NUM_REQ-1)) ? '0 : w_acc_id + ID_W'(1);
            w_state_nxt = req_lock[w_acc_id] ? LOCKED : IDLE;
        end
    end

    assign w_acc_rd  = w_accept & ~req_wen[w_acc_id];
    assign req_ready = w_ready;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_owner <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_owner <= w_owner_nxt;
        end
    end

    // Registered RAM command; address and data hold when idle to avoid toggling.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_en      <= 1'b0;
            ram_wen     <= 1'b0;
            ram_addr    <= '0;
            ram_wr_data <= '0;
        end else begin
            ram_en  <= w_accept;
            ram_wen <= w_accept & req_wen[w_acc_id];
            if (w_accept) begin
                ram_addr    <= req_addr[w_acc_id*ADDR_W +: ADDR_W];
                ram_wr_data <= req_wdata[w_acc_id*DATA_W +: DATA_W];
            end
        end
    end

    // NOTE: the tag pipeline is reset in full, ids included, so a reset can never
    // release a stale tag and produce a phantom response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag_v <= '0;
            for (int s = 0; s < PIPE; s++) begin
                r_tag_id[s] <= '0;
            end
        end else begin
            r_tag_v     <= {r_tag_v[PIPE-2:0], w_acc_rd};
            r_tag_id[0] <= w_acc_id;
            for (int s = 1; s < PIPE; s++) begin
                r_tag_id[s] <= r_tag_id[s-1];
            end
        end
    end

    always_comb begin
        rsp_valid = '0;
        if (r_tag_v[PIPE-1]) begin
            rsp_valid[r_tag_id[PIPE-1]] = 1'b1;
        end
    end

    assign rsp_data = ram_rd_data;
    assign owner    = r_owner;

    a_ready_onehot : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(req_ready));
    a_rsp_onehot   : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(rsp_valid));

endmodule

// File: tb/tb_paillier_ram_arbiter.sv
// Self-checking bench for paillier_ram_arbiter: RAM model, per-requester beat queues,
// a cycle-level reference model compared every cycle, and directed literal checks.
module tb_paillier_ram_arbiter;

    localparam int N   = 4;
    localparam int AW  = 11;
    localparam int DW  = 64;
    localparam int LAT = 1;

    logic            clk   = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    req_wen   = '0;
    logic [N*AW-1:0] req_addr  = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic [N-1:0]    req_lock  = '0;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_data;
    logic            ram_wen;
    logic [AW-1:0]   ram_addr;
    logic [DW-1:0]   ram_wr_data;
    logic [DW-1:0]   ram_rd_data;
    logic            ram_en;
    logic [1:0]      owner;

    always #5 clk = ~clk;

    paillier_ram_arbiter #(
        .NUM_REQ (N),
        .DATA_W  (DW),
        .ADDR_W  (AW),
        .RD_LAT  (LAT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_wen     (req_wen),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_lock    (req_lock),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .ram_wen     (ram_wen),
        .ram_addr    (ram_addr),
        .ram_wr_data (ram_wr_data),
        .ram_rd_data (ram_rd_data),
        .ram_en      (ram_en),
        .owner       (owner)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] init_val(input logic [AW-1:0] a);
        return {32'hA5A5_5A5A, 21'd0, a};
    endfunction

    // Single-port RAM with one-cycle read latency; unwritten words read a known pattern.
    logic [DW-1:0] ram_mem [0:2047];
    bit            ram_wr  [0:2047];
    logic [DW-1:0] ram_q = '0;
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_wen) begin
                ram_mem[ram_addr] <= ram_wr_data;
                ram_wr[ram_addr]  <= 1'b1;
            end else begin
                ram_q <= ram_wr[ram_addr] ? ram_mem[ram_addr] : init_val(ram_addr);
            end
        end
    end
    assign ram_rd_data = ram_q;

    typedef struct {
        bit            gap;
        bit            wen;
        bit            lock;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } beat_t;

    typedef struct {
        int            due;
        int            id;
        logic [DW-1:0] data;
    } rsp_t;

    beat_t bq [N][$];

    function automatic beat_t mk(input bit wen, input bit lock, input int addr, input logic [DW-1:0] data);
        beat_t b;
        b.gap  = 1'b0;
        b.wen  = wen;
        b.lock = lock;
        b.addr = AW'(addr);
        b.data = data;
        return b;
    endfunction

    function automatic beat_t gap_beat();
        beat_t b;
        b.gap  = 1'b1;
        b.wen  = 1'b0;
        b.lock = 1'b0;
        b.addr = '0;
        b.data = '0;
        return b;
    endfunction

    // Requester driver: presents the head of each queue, pops on handshake or after a gap cycle.
    initial begin : driver
        logic [N-1:0] acc;
        bit           pres_gap [N];
        beat_t        b;
        for (int i = 0; i < N; i++) pres_gap[i] = 1'b0;
        forever begin
            @(negedge clk);
            acc = rst_n ? (req_valid & req_ready) : '0;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (bq[i].size() > 0 && (acc[i] || pres_gap[i])) void'(bq[i].pop_front());
                pres_gap[i] = 1'b0;
                if (bq[i].size() > 0) begin
                    b                     = bq[i][0];
                    req_valid[i]          = !b.gap;
                    req_wen[i]            = b.wen;
                    req_lock[i]           = b.lock;
                    req_addr[i*AW +: AW]  = b.addr;
                    req_wdata[i*DW +: DW] = b.data;
                    pres_gap[i]           = b.gap;
                end else begin
                    req_valid[i] = 1'b0;
                    req_wen[i]   = 1'b0;
                    req_lock[i]  = 1'b0;
                end
            end
        end
    end

    // Reference model: arbitration rules in plain integers, memory contents as a map.
    int            m_ptr = 0;
    bit            m_locked = 1'b0;
    int            m_owner = 0;
    bit            e_en = 1'b0, e_wen = 1'b0;
    logic [AW-1:0] e_addr = '0;
    logic [DW-1:0] e_wdata = '0;
    rsp_t          rsp_q[$];
    logic [DW-1:0] shadow [int];
    int            grant_log[$];
    int            grant_cyc[$];
    int            rsp_log[$];
    int            cyc = 0;

    initial begin : compare
        logic [N-1:0]  exp_ready, exp_rv;
        logic [AW-1:0] a;
        rsp_t          r;
        int            j;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check("rst_ram_en", ram_en, 0);
                check("rst_ram_wen", ram_wen, 0);
                check("rst_rsp_valid", rsp_valid, 0);
                check("rst_owner", owner, 0);
                m_ptr    = 0;
                m_locked = 1'b0;
                m_owner  = 0;
                e_en     = 1'b0;
                e_wen    = 1'b0;
                rsp_q.delete();
            end else begin
                exp_ready = '0;
                if (m_locked) begin
                    exp_ready[m_owner] = req_valid[m_owner];
                end else begin
                    for (int k = 0; k < N; k++) begin
                        j = (m_ptr + k) % N;
                        if (exp_ready == '0 && req_valid[j]) exp_ready[j] = 1'b1;
                    end
                end
                check("req_ready", req_ready, exp_ready);
                check("ram_en", ram_en, e_en);
                check("ram_wen", ram_wen, e_wen);
                if (e_en) check("ram_addr", ram_addr, e_addr);
                if (e_en && e_wen) check("ram_wr_data", ram_wr_data, e_wdata);
                exp_rv = '0;
                if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
                    r = rsp_q.pop_front();
                    exp_rv[r.id] = 1'b1;
                    check("rsp_data", rsp_data, r.data);
                end
                check("rsp_valid", rsp_valid, exp_rv);
                if (rsp_valid != '0) begin
                    for (int i = 0; i < N; i++) if (rsp_valid[i]) rsp_log.push_back(i);
                end
                check("owner", owner, m_owner);
                e_en  = 1'b0;
                e_wen = 1'b0;
                for (int i = 0; i < N; i++) begin
                    if (exp_ready[i]) begin
                        a       = req_addr[i*AW +: AW];
                        e_en    = 1'b1;
                        e_wen   = req_wen[i];
                        e_addr  = a;
                        e_wdata = req_wdata[i*DW +: DW];
                        if (req_wen[i]) begin
                            shadow[int'(a)] = req_wdata[i*DW +: DW];
                        end else begin
                            r.due  = cyc + 1 + LAT;
                            r.id   = i;
                            r.data = shadow.exists(int'(a)) ? shadow[int'(a)] : init_val(a);
                            rsp_q.push_back(r);
                        end
                        m_owner  = i;
                        m_ptr    = (i + 1) % N;
                        m_locked = req_lock[i];
                        grant_log.push_back(i);
                        grant_cyc.push_back(cyc);
                    end
                end
            end
            cyc++;
        end
    end

    task automatic wait_acc(input int id, input int budget);
        bit seen = 1'b0;
        int n    = 0;
        while (!seen && n < budget) begin
            @(negedge clk);
            n++;
            if (req_valid[id] && req_ready[id]) seen = 1'b1;
        end
        check("accept_seen", seen, 1);
    endtask

    task automatic wait_idle(input int budget);
        bit busy = 1'b1;
        int n    = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
            busy = (rsp_q.size() > 0) || (req_valid != '0) || ram_en;
            for (int i = 0; i < N; i++) if (bq[i].size() > 0) busy = 1'b1;
        end
        check("drain_done", busy, 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        // Idle: nothing requested, nothing issued.
        repeat (20) begin
            @(negedge clk);
            check("idle_ram_en", ram_en, 0);
            check("idle_rsp_valid", rsp_valid, 0);
            check("idle_req_ready", req_ready, 0);
        end

        // Requester 2: write then back-to-back read of the same word.
        bq[2].push_back(mk(1'b1, 1'b0, 'h005, 64'hDEAD_BEEF_0000_0001));
        bq[2].push_back(mk(1'b0, 1'b0, 'h005, 64'h0));
        wait_acc(2, 50);
        @(negedge clk);
        check("wr_ram_en", ram_en, 1);
        check("wr_ram_wen", ram_wen, 1);
        check("wr_ram_addr", ram_addr, 'h005);
        check("wr_ram_wr_data", ram_wr_data, 64'hDEAD_BEEF_0000_0001);
        check("rd_ready", req_ready, 4'b0100);
        @(negedge clk);
        check("rd_ram_en", ram_en, 1);
        check("rd_ram_wen", ram_wen, 0);
        @(negedge clk);
        check("rd_rsp_valid", rsp_valid, 4'b0100);
        check("rd_rsp_data", rsp_data, 64'hDEAD_BEEF_0000_0001);
        wait_idle(100);

        // All four stream reads; pointer sits at 3 after requester 2's grants.
        grant_log.delete(); grant_cyc.delete(); rsp_log.delete();
        for (int n = 0; n < 4; n++)
            for (int i = 0; i < N; i++) bq[i].push_back(mk(1'b0, 1'b0, 'h300 + i*16 + n, 64'h0));
        wait_idle(200);
        check("rr_grants", grant_log.size(), 16);
        check("rr_rsps", rsp_log.size(), 16);
        if (grant_log.size() == 16 && rsp_log.size() == 16) begin
            for (int k = 0; k < 16; k++) begin
                check("rr_order", grant_log[k], (3 + k) % 4);
                check("rr_rsp_order", rsp_log[k], (3 + k) % 4);
                if (k > 0) check("rr_back_to_back", grant_cyc[k] - grant_cyc[k-1], 1);
            end
        end

        // 32-beat locked burst from requester 1 with a 3-cycle valid gap; 0 and 3 waiting.
        grant_log.delete(); grant_cyc.delete(); rsp_log.delete();
        for (int b = 0; b < 32; b++) begin
            if (b == 16) repeat (3) bq[1].push_back(gap_beat());
            bq[1].push_back(mk(b % 2 == 0, b != 31, 'h200 + b - (b % 2), {32'hB0B0_0000, 32'(b)}));
        end
        bq[0].push_back(gap_beat());
        bq[0].push_back(mk(1'b0, 1'b0, 'h100, 64'h0));
        bq[3].push_back(gap_beat());
        bq[3].push_back(mk(1'b0, 1'b0, 'h103, 64'h0));
        wait_idle(300);
        check("burst_grants", grant_log.size(), 34);
        if (grant_log.size() == 34) begin
            for (int k = 0; k < 32; k++) check("burst_owner", grant_log[k], 1);
            check("burst_next_grant", grant_log[32], 3);
            check("burst_then_grant", grant_log[33], 0);
            check("burst_gap_cycles", grant_cyc[16] - grant_cyc[15], 4);
        end

        // Reset with reads in flight and a burst open.
        for (int b = 0; b < 8; b++) bq[1].push_back(mk(1'b0, 1'b1, 'h010 + b, 64'h0));
        wait_acc(1, 50);
        wait_acc(1, 50);
        #1;
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) bq[i].delete();
        req_valid = '0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        grant_log.delete(); grant_cyc.delete(); rsp_log.delete();
        bq[0].push_back(mk(1'b0, 1'b0, 'h020, 64'h0));
        bq[3].push_back(mk(1'b0, 1'b0, 'h023, 64'h0));
        wait_idle(100);
        check("post_rst_grants", grant_log.size(), 2);
        check("post_rst_rsps", rsp_log.size(), 2);
        if (grant_log.size() == 2 && rsp_log.size() == 2) begin
            check("post_rst_first", grant_log[0], 0);
            check("post_rst_second", grant_log[1], 3);
            check("post_rst_rsp_first", rsp_log[0], 0);
            check("post_rst_rsp_second", rsp_log[1], 3);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
